riscv_trace_buf: RTL and testbench

RISCV_TRACE_BUF -- requirements
Module: riscv_trace_buf

---
 rtl/riscv_trace_buf_pkg.sv | 31 +++
 rtl/riscv_trace_ram.sv | 24 ++
 rtl/riscv_trace_buf.sv | 134 +++++++++++++
 tb/tb_riscv_trace_buf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_buf_pkg.sv
// rtl/riscv_trace_buf_pkg.sv - shared state encodings and trace entry layout
package riscv_trace_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DUMP  = 3'd4
    } trace_state_t;

    localparam int WA_W = 5;

    // Entry layout, MSB first: {pc, we, wa, wd}
    function automatic int entry_w(input int dw);
        return 2 * dw + WA_W + 1;
    endfunction

    function automatic int wa_lsb(input int dw);
        return dw;
    endfunction

    function automatic int we_bit(input int dw);
        return dw + WA_W;
    endfunction

    function automatic int pc_lsb(input int dw);
        return dw + WA_W + 1;
    endfunction

endpackage

// File: rtl/riscv_trace_ram.sv
// rtl/riscv_trace_ram.sv - trace storage, one synchronous write port and one asynchronous read port
module riscv_trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_trace_buf.sv
// rtl/riscv_trace_buf.sv - retirement trace buffer with PC trigger, post-trigger capture and handshake dump
module riscv_trace_buf
    import riscv_trace_buf_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int DWIDTH    = 32,
    parameter int POST_TRIG = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     cap_valid,
    input  logic [DWIDTH-1:0]        cap_pc,
    input  logic                     cap_we,
    input  logic [4:0]               cap_wa,
    input  logic [DWIDTH-1:0]        cap_wd,
    input  logic                     trig_en,
    input  logic [DWIDTH-1:0]        trig_pc,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [2*DWIDTH+5:0]      dump_data,
    output logic [2:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int EW     = entry_w(DWIDTH);
    localparam int PC_LSB = pc_lsb(DWIDTH);
    localparam int WE_BIT = we_bit(DWIDTH);
    localparam int WA_LSB = wa_lsb(DWIDTH);
    localparam int PW     = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PW-1:0]    POST_LOAD = PW'(POST_TRIG);
    localparam logic [PW-1:0]    POST_ONE  = PW'(1);

    trace_state_t  st;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [PW-1:0] post_left;
    logic [EW-1:0] wentry;
    logic          capture;
    logic          trig_hit;
    logic          pop;

    // An arm pulse always wins, so it also suppresses the write in that cycle
    assign capture    = cap_valid && !arm && (st == ST_ARMED || st == ST_POST);
    assign trig_hit   = trig_en && cap_valid && (cap_pc == trig_pc);
    assign dump_valid = (st == ST_DONE || st == ST_DUMP) && (count != '0);
    assign pop        = dump_valid && dump_ready;
    assign rptr       = wptr - count[AW-1:0];
    assign state      = st;

    always_comb begin
        wentry = '0;
        wentry[PC_LSB +: DWIDTH] = cap_pc;
        wentry[WE_BIT]           = cap_we;
        wentry[WA_LSB +: WA_W]   = cap_wa;
        wentry[0 +: DWIDTH]      = cap_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            wptr      <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            post_left <= '0;
        end else if (arm) begin
            st        <= ST_ARMED;
            wptr      <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            post_left <= POST_LOAD;
        end else begin
            if (capture) begin
                wptr <= wptr + AW'(1);
                if (count == CNT_FULL) begin
                    wrapped <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
            end
            if (pop) begin
                count <= count - CNT_ONE;
            end
            case (st)
                ST_ARMED: begin
                    if (trig_hit) begin
                        st <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (cap_valid) begin
                        post_left <= post_left - POST_ONE;
                        if (post_left == POST_ONE) begin
                            st <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (pop) begin
                        st <= (count == CNT_ONE) ? ST_IDLE : ST_DUMP;
                    end else if (count == '0 && dump_ready) begin
                        st <= ST_IDLE;
                    end
                end
                ST_DUMP: begin
                    if (pop && count == CNT_ONE) begin
                        st <= ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    riscv_trace_ram #(
        .DEPTH(DEPTH),
        .WIDTH(EW)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wptr),
        .wdata (wentry),
        .raddr (rptr),
        .rdata (dump_data)
    );

endmodule

// File: tb/tb_riscv_trace_buf.sv
// tb/tb_riscv_trace_buf.sv - directed self-checking bench for riscv_trace_buf
module tb_riscv_trace_buf;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_POST  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DUMP  = 3'd4;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        cap_valid;
    logic [31:0] cap_pc;
    logic        cap_we;
    logic [4:0]  cap_wa;
    logic [31:0] cap_wd;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        dump_ready;

    logic        a_dump_valid;
    logic [69:0] a_dump_data;
    logic [2:0]  a_state;
    logic [3:0]  a_count;
    logic        a_wrapped;

    logic        b_dump_valid;
    logic [69:0] b_dump_data;
    logic [2:0]  b_state;
    logic [2:0]  b_count;
    logic        b_wrapped;

    int vectors;
    int miscompares;

    riscv_trace_buf #(.DEPTH(8), .DWIDTH(32), .POST_TRIG(2)) u_a (
        .clk(clk), .rst(rst), .arm(arm), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_we(cap_we), .cap_wa(cap_wa), .cap_wd(cap_wd), .trig_en(trig_en),
        .trig_pc(trig_pc), .dump_valid(a_dump_valid), .dump_ready(dump_ready),
        .dump_data(a_dump_data), .state(a_state), .count(a_count), .wrapped(a_wrapped)
    );

    riscv_trace_buf #(.DEPTH(4), .DWIDTH(32), .POST_TRIG(0)) u_b (
        .clk(clk), .rst(rst), .arm(arm), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_we(cap_we), .cap_wa(cap_wa), .cap_wd(cap_wd), .trig_en(trig_en),
        .trig_pc(trig_pc), .dump_valid(b_dump_valid), .dump_ready(dump_ready),
        .dump_data(b_dump_data), .state(b_state), .count(b_count), .wrapped(b_wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [69:0] ent(input logic [31:0] pc);
        return {pc, 1'b1, pc[6:2], ~pc};
    endfunction

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic cap(input logic [31:0] pc);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_we    = 1'b1;
        cap_wa    = pc[6:2];
        cap_wd    = ~pc;
        step();
        cap_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; arm = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_we = 1'b0;
        cap_wa = '0; cap_wd = '0; trig_en = 1'b0; trig_pc = '0; dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 70'(a_state), 70'(S_IDLE));
        check("rst_count", 70'(a_count), 70'd0);
        check("rst_wrapped", 70'(a_wrapped), 70'd0);
        check("rst_dump_valid", 70'(a_dump_valid), 70'd0);
        rst = 1'b0;
        step();

        // Free-running capture without trigger, then re-arm
        do_arm();
        check("arm_state", 70'(a_state), 70'(S_ARMED));
        for (int i = 0; i < 10; i++) cap(32'(i * 4));
        check("notrig_state", 70'(a_state), 70'(S_ARMED));
        check("notrig_count_sat", 70'(a_count), 70'd8);
        check("notrig_wrapped", 70'(a_wrapped), 70'd1);
        do_arm();
        check("rearm_state", 70'(a_state), 70'(S_ARMED));
        check("rearm_count", 70'(a_count), 70'd0);
        check("rearm_wrapped", 70'(a_wrapped), 70'd0);
        check("rearm_dump_valid", 70'(a_dump_valid), 70'd0);

        // Wrapped window around trigger PC 0x28
        trig_en = 1'b1;
        trig_pc = 32'h28;
        for (int i = 0; i < 20; i++) cap(32'(i * 4));
        check("win_state", 70'(a_state), 70'(S_DONE));
        check("win_count", 70'(a_count), 70'd8);
        check("win_wrapped", 70'(a_wrapped), 70'd1);
        check("win_dump_valid", 70'(a_dump_valid), 70'd1);
        dump_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("win_dump_data", a_dump_data, ent(32'h14 + 32'(i * 4)));
            step();
        end
        check("win_end_state", 70'(a_state), 70'(S_IDLE));
        check("win_end_count", 70'(a_count), 70'd0);
        check("win_end_dump_valid", 70'(a_dump_valid), 70'd0);
        dump_ready = 1'b0;

        // Trigger on the first entry with no post-trigger capture (instance b)
        do_arm();
        trig_pc = 32'h100;
        cap(32'h100);
        check("b_first_state", 70'(b_state), 70'(S_DONE));
        check("b_first_count", 70'(b_count), 70'd1);
        check("b_first_pc", 70'(b_dump_data[69:38]), 70'h100);
        check("a_post_state", 70'(a_state), 70'(S_POST));

        // Stalled dump with ready pattern 1,0,0,1
        cap(32'h104);
        cap(32'h108);
        check("stall_state", 70'(a_state), 70'(S_DONE));
        check("stall_count", 70'(a_count), 70'd3);
        check("stall_data0", a_dump_data, ent(32'h100));
        dump_ready = 1'b1;
        step();
        check("stall_pop1_state", 70'(a_state), 70'(S_DUMP));
        check("stall_pop1_data", a_dump_data, ent(32'h104));
        check("b_pop_state", 70'(b_state), 70'(S_IDLE));
        dump_ready = 1'b0;
        step();
        check("stall_hold1_data", a_dump_data, ent(32'h104));
        check("stall_hold1_count", 70'(a_count), 70'd2);
        step();
        check("stall_hold2_data", a_dump_data, ent(32'h104));
        check("stall_hold2_valid", 70'(a_dump_valid), 70'd1);
        dump_ready = 1'b1;
        step();
        check("stall_pop2_data", a_dump_data, ent(32'h108));
        check("stall_pop2_count", 70'(a_count), 70'd1);
        step();
        check("stall_end_state", 70'(a_state), 70'(S_IDLE));
        check("stall_end_count", 70'(a_count), 70'd0);
        dump_ready = 1'b0;

        // Asynchronous reset mid-POST
        do_arm();
        trig_pc = 32'h200;
        cap(32'h200);
        check("midpost_state", 70'(a_state), 70'(S_POST));
        #2 rst = 1'b1;
        #1;
        check("rst_post_state", 70'(a_state), 70'(S_IDLE));
        check("rst_post_count", 70'(a_count), 70'd0);
        check("rst_post_b_valid", 70'(b_dump_valid), 70'd0);
        rst = 1'b0;
        step();

        // Asynchronous reset mid-DUMP
        do_arm();
        trig_pc = 32'h300;
        cap(32'h300);
        cap(32'h304);
        cap(32'h308);
        dump_ready = 1'b1;
        step();
        check("middump_state", 70'(a_state), 70'(S_DUMP));
        check("middump_count", 70'(a_count), 70'd2);
        dump_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_dump_state", 70'(a_state), 70'(S_IDLE));
        check("rst_dump_count", 70'(a_count), 70'd0);
        check("rst_dump_valid", 70'(a_dump_valid), 70'd0);
        rst = 1'b0;
        step();
        check("rst_dump_after", 70'(a_state), 70'(S_IDLE));

        // Arm coinciding with a matching trigger restarts the session
        do_arm();
        trig_pc = 32'h400;
        cap(32'h3FC);
        check("prearm_count", 70'(a_count), 70'd1);
        arm = 1'b1;
        cap(32'h400);
        arm = 1'b0;
        check("armtrig_state", 70'(a_state), 70'(S_ARMED));
        check("armtrig_count", 70'(a_count), 70'd0);
        check("armtrig_b_state", 70'(b_state), 70'(S_ARMED));
        step();
        check("armtrig_hold_state", 70'(a_state), 70'(S_ARMED));
        check("armtrig_hold_valid", 70'(a_dump_valid), 70'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
